sub_share_arbiter: RTL and testbench

//  Shares one 32-bit subtract/set-less-than datapath among NREQ requesters.

---
 rtl/sub_share_arbiter.sv | 127 ++++++++++++
 tb/tb_sub_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sub_share_arbiter.sv
// Round-robin shared subtract/SLT unit: accept one request, execute, hold the response.
// Optional build macro SLT_OVF_FIX_EN selects a true signed SLT instead of the raw sign bit.
module sub_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_z,
  output logic              rsp_o,
  output logic              rsp_c,
  output logic              rsp_n,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_next;
  logic [IDW-1:0] ptr, ptr_next;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           accept;
  logic           op_lat;
  logic [31:0]    a_lat, b_lat;

  logic [32:0]    sum;
  logic [31:0]    diff;
  logic           carry, ovf, lt;

  // Search starts at ptr and wraps, so the most recently served requester goes last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign accept = rst_n && (state == IDLE) && grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
          ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      EXEC: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single shared subtractor: A + ~B + 1, carry-out means no borrow.
  assign sum   = {1'b0, a_lat} + {1'b0, ~b_lat} + 33'd1;
  assign diff  = sum[31:0];
  assign carry = sum[32];
  assign ovf   = (a_lat[31] != b_lat[31]) && (diff[31] != a_lat[31]);
`ifdef SLT_OVF_FIX_EN
  assign lt    = diff[31] ^ ovf;
`else
  assign lt    = diff[31];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_lat    <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_z     <= 1'b0;
      rsp_o     <= 1'b0;
      rsp_c     <= 1'b0;
      rsp_n     <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      rsp_valid <= (state_next == RESP);
      if (accept) begin
        op_lat <= req_op[grant_idx];
        a_lat  <= req_a[32*grant_idx +: 32];
        b_lat  <= req_b[32*grant_idx +: 32];
        rsp_id <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_data <= op_lat ? {31'b0, lt} : diff;
        rsp_z    <= (diff == 32'd0);
        rsp_o    <= ovf;
        rsp_c    <= carry;
        rsp_n    <= diff[31];
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Self-checking bench for sub_share_arbiter: directed scenarios plus randomized traffic
// against an arithmetic reference model and a round-robin pointer model.
module tb_sub_share_arbiter;
  localparam int NREQ = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_op;
  logic [127:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_z, rsp_o, rsp_c, rsp_n, busy;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  always #5 clk = ~clk;

  sub_share_arbiter #(.NREQ(NREQ), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_c(rsp_c),
    .rsp_n(rsp_n), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {z, o, c, n, data} from signed/unsigned arithmetic on the operands.
  function automatic logic [35:0] ref_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sd;
    logic [31:0] d;
    logic z, o, c, n, lt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = sa - sb;
    d  = a - b;
    z  = (d == 32'd0);
    n  = d[31];
    c  = (a >= b);
    o  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`ifdef SLT_OVF_FIX_EN
    lt = (sa < sb);
`else
    lt = n;
`endif
    return {z, o, c, n, (op ? {31'b0, lt} : d)};
  endfunction

  task automatic set_req(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    req_op[i]       = op;
    req_a[32*i+:32] = a;
    req_b[32*i+:32] = b;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1 with the DUT idle and the request inputs already applied.
  task automatic txn(input int stall, input bit scramble);
    int g;
    int idx;
    logic [35:0] e;
    logic op;
    logic [31:0] a, b;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    #1;
    if (g < 0) begin
      chk("no_req_ready", req_ready, 0);
      @(posedge clk); #1;
      chk("no_req_busy", busy, 0);
      $display("txn none valid=%b", req_valid);
      return;
    end
    chk("grant", req_ready, 4'b1 << g);
    chk("idle_busy", busy, 0);
    op = req_op[g];
    a  = req_a[32*g+:32];
    b  = req_b[32*g+:32];
    e  = ref_model(op, a, b);
    ptr_m = (g + 1) % NREQ;

    @(posedge clk); #1;
    if (scramble) begin
      req_valid = 4'($urandom);
      req_op    = 4'($urandom);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
    end
    rsp_ready = (stall == 0);
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    chk("exec_valid", rsp_valid, 0);

    @(posedge clk); #1;
    for (int s = 0; s <= stall; s++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_data", rsp_data, e[31:0]);
      chk("rsp_flags", {rsp_z, rsp_o, rsp_c, rsp_n}, e[35:32]);
      chk("resp_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
      if (s == stall) rsp_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("post_valid", rsp_valid, 0);
    chk("post_busy", busy, 0);
    $display("txn id=%0d op=%0d a=%h b=%h data=%h zocn=%b stall=%0d",
             g, op, a, b, e[31:0], e[35:32], stall);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {rsp_z, rsp_o, rsp_c, rsp_n}, 0);
    chk("rst_busy", busy, 0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic SUB, SLT overflow cases and SUB boundaries.
    set_req(0, 1'b0, 32'd5, 32'd3);            req_valid = 4'b0001; txn(0, 1);
    set_req(1, 1'b1, 32'h8000_0000, 32'd1);    req_valid = 4'b0010; txn(0, 1);
    set_req(2, 1'b1, 32'hFFFF_FFFF, 32'd0);    req_valid = 4'b0100; txn(0, 1);
    set_req(3, 1'b0, 32'd7, 32'd7);            req_valid = 4'b1000; txn(0, 1);
    set_req(0, 1'b0, 32'd0, 32'd1);            req_valid = 4'b0001; txn(1, 1);

    // Reset during EXEC drops the transaction and restarts the pointer.
    set_req(2, 1'b0, 32'd100, 32'd1);
    req_valid = 4'b0100;
    #1;
    chk("r5_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("r5_valid", rsp_valid, 0);
    chk("r5_busy", busy, 0);
    chk("r5_data", rsp_data, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    req_valid = '0;
    @(posedge clk); #1;
    chk("r5_no_rsp", rsp_valid, 0);

    // All requesters held valid: strict rotation 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'd1000 + 32'(i), 32'(i));
    for (int t = 0; t < 5; t++) begin
      req_valid = 4'hF;
      txn(0, 0);
    end

    // Long back-pressure in RESP.
    req_valid = 4'b0110;
    set_req(2, 1'b1, 32'd3, 32'd9);
    txn(5, 1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom_range(0, 1)), pick(), pick());
      req_valid = 4'($urandom_range(0, 15));
      txn($urandom_range(0, 3), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
